// File: rtl/ccsds_123b2_selfcheck_sequencer.sv
// Campaign sequencer for the CCSDS-123 selfcheck wrapper: reset, init pulse, supervised run, repeat.
// Registered outputs (busy/done/pass decoded); abort ends a campaign one cycle later; no backpressure.
module ccsds_123b2_selfcheck_sequencer #(
    parameter int CNT_W        = 32,
    parameter int RESET_CYCLES = 128,
    parameter int RUN_TIMEOUT  = 218000,
    parameter int NUM_RUNS     = 4,
    parameter bit STOP_ON_FAIL = 1'b0,
    parameter int RUN_W        = $clog2(NUM_RUNS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             core_rst,
    output logic             core_init,
    input  logic             core_full_fin,
    input  logic             core_full_fail,
    input  logic             core_ref_fin,
    input  logic             core_ref_fail,
    input  logic             core_timeout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             aborted,
    output logic [RUN_W-1:0] run_cnt,
    output logic [RUN_W-1:0] fail_cnt,
    output logic [3:0]       last_status
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_INIT,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_TIMEOUT - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [RUN_W-1:0] run_cnt_q;
    logic [RUN_W-1:0] fail_cnt_q;
    logic [3:0]       last_status_q;
    logic             aborted_q;
    logic             core_rst_q;
    logic             core_init_q;
    logic             full_fin_q;
    logic             ref_fin_q;
    logic             full_fail_q;
    logic             ref_fail_q;

    logic             full_fin_d;
    logic             ref_fin_d;
    logic             full_fail_d;
    logic             ref_fail_d;
    logic             completed;
    logic             wdog;
    logic             run_end;
    logic             run_fail;
    logic             campaign_end;
    logic [3:0]       status_d;
    logic [RUN_W-1:0] run_cnt_d;

    // End-of-run decode uses latched|current flags; only consumed while in RUN.
    always_comb begin
        full_fin_d   = full_fin_q  | core_full_fin;
        ref_fin_d    = ref_fin_q   | core_ref_fin;
        full_fail_d  = full_fail_q | core_full_fail;
        ref_fail_d   = ref_fail_q  | core_ref_fail;
        completed    = full_fin_d & ref_fin_d;
        wdog         = (cnt_q == RUN_LAST) & ~completed & ~core_timeout;
        status_d     = {wdog, core_timeout, ref_fail_d, full_fail_d};
        run_end      = completed | core_timeout | wdog;
        run_fail     = |status_d;
        run_cnt_d    = run_cnt_q + RUN_W'(1);
        campaign_end = (run_cnt_d == RUN_W'(NUM_RUNS)) | (STOP_ON_FAIL & run_fail);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            run_cnt_q     <= '0;
            fail_cnt_q    <= '0;
            last_status_q <= '0;
            aborted_q     <= 1'b0;
            core_rst_q    <= 1'b1;
            core_init_q   <= 1'b0;
            full_fin_q    <= 1'b0;
            ref_fin_q     <= 1'b0;
            full_fail_q   <= 1'b0;
            ref_fail_q    <= 1'b0;
        end else begin
            core_init_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q       <= S_RESET;
                        cnt_q         <= '0;
                        run_cnt_q     <= '0;
                        fail_cnt_q    <= '0;
                        last_status_q <= '0;
                        aborted_q     <= 1'b0;
                        core_rst_q    <= 1'b1;
                    end
                end
                S_RESET: begin
                    if (abort) begin
                        state_q    <= S_DONE;
                        aborted_q  <= 1'b1;
                        core_rst_q <= 1'b1;
                    end else if (cnt_q == RST_LAST) begin
                        state_q     <= S_INIT;
                        core_rst_q  <= 1'b0;
                        core_init_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_INIT: begin
                    if (abort) begin
                        state_q    <= S_DONE;
                        aborted_q  <= 1'b1;
                        core_rst_q <= 1'b1;
                    end else begin
                        state_q     <= S_RUN;
                        cnt_q       <= '0;
                        full_fin_q  <= 1'b0;
                        ref_fin_q   <= 1'b0;
                        full_fail_q <= 1'b0;
                        ref_fail_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state_q    <= S_DONE;
                        aborted_q  <= 1'b1;
                        core_rst_q <= 1'b1;
                    end else begin
                        full_fin_q  <= full_fin_d;
                        ref_fin_q   <= ref_fin_d;
                        full_fail_q <= full_fail_d;
                        ref_fail_q  <= ref_fail_d;
                        if (run_end) begin
                            run_cnt_q     <= run_cnt_d;
                            last_status_q <= status_d;
                            if (run_fail) begin
                                fail_cnt_q <= fail_cnt_q + RUN_W'(1);
                            end
                            cnt_q      <= '0;
                            core_rst_q <= 1'b1;
                            state_q    <= campaign_end ? S_DONE : S_RESET;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    core_rst_q <= 1'b1;
                end
            endcase
        end
    end

    assign core_rst    = core_rst_q;
    assign core_init   = core_init_q;
    assign run_cnt     = run_cnt_q;
    assign fail_cnt    = fail_cnt_q;
    assign last_status = last_status_q;
    assign aborted     = aborted_q;
    assign busy        = (state_q == S_RESET) | (state_q == S_INIT) | (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign pass        = done & (fail_cnt_q == '0) & ~aborted_q & (run_cnt_q == RUN_W'(NUM_RUNS));

endmodule
